scratchpad_bank_driver: RTL and testbench

Client-side driver for the scratchpad bank: the engine that talks to the bank's `sp` modport from the outside. It turns sequencer commands and a DRAM load stream into `wFIFO`/`rFIFO` pushes, then tracks completion. It also drains `dramFIFO` and `gemmFIFO` into registered valid/ready output streams toward the DRAM store path and the GEMM array. It sits between the tensor-core sequencer/DRAM adapter and `scratchpad_bank`.

---
 rtl/sp_types_pkg.sv | 46 ++++
 rtl/scratchpad_bank_if.sv | 46 ++++
 rtl/sp_drain_stage.sv | 32 +++
 rtl/scratchpad_bank_driver.sv | 188 ++++++++++++++++++
 tb/tb_scratchpad_bank_driver.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_types_pkg.sv
// Shared types for the scratchpad bank driver.
// Bank FIFO entry layouts and engine state enums.
package sp_types_pkg;

  localparam int SP_DATA_W = 64;
  localparam int SP_ROWS   = 4;
  localparam int SP_MAT_W  = 4;
  localparam int SP_ROW_W  = $clog2(SP_ROWS);

  typedef struct packed {
    logic [SP_MAT_W-1:0]  mat;
    logic [SP_ROW_W-1:0]  row;
    logic [SP_DATA_W-1:0] data;
  } wFIFO_t;

  typedef struct packed {
    logic [SP_MAT_W-1:0] a;
    logic [SP_MAT_W-1:0] b;
    logic [SP_MAT_W-1:0] c;
    logic [SP_MAT_W-1:0] d;
  } rFIFO_t;

  typedef struct packed {
    logic [SP_MAT_W-1:0]  mat;
    logic [SP_ROW_W-1:0]  row;
    logic [SP_DATA_W-1:0] data;
  } dramFIFO_t;

  typedef struct packed {
    logic [SP_DATA_W-1:0] aRow;
    logic [SP_DATA_W-1:0] bRow;
  } gemmFIFO_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PUSH,
    W_WAIT
  } wState_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PUSH,
    R_WAIT
  } rState_t;

endpackage

// File: rtl/scratchpad_bank_if.sv
// Scratchpad bank FIFO interface.
// sp: bank side; drv: client (driver) side.
interface scratchpad_bank_if
  import sp_types_pkg::*;
;

  logic      wFIFO_WEN;
  wFIFO_t    wFIFO_wdata;
  logic      wFIFO_full;

  logic      rFIFO_WEN;
  rFIFO_t    rFIFO_wdata;
  logic      rFIFO_full;

  logic      dramFIFO_REN;
  dramFIFO_t dramFIFO_rdata;
  logic      dramFIFO_empty;

  logic      gemmFIFO_REN;
  gemmFIFO_t gemmFIFO_rdata;
  logic      gemmFIFO_empty;

  logic      load_complete;
  logic      gemm_complete;

  modport sp (
    input  wFIFO_WEN, wFIFO_wdata,
    input  rFIFO_WEN, rFIFO_wdata,
    input  dramFIFO_REN, gemmFIFO_REN,
    output wFIFO_full, rFIFO_full,
    output dramFIFO_rdata, dramFIFO_empty,
    output gemmFIFO_rdata, gemmFIFO_empty,
    output load_complete, gemm_complete
  );

  modport drv (
    output wFIFO_WEN, wFIFO_wdata,
    output rFIFO_WEN, rFIFO_wdata,
    output dramFIFO_REN, gemmFIFO_REN,
    input  wFIFO_full, rFIFO_full,
    input  dramFIFO_rdata, dramFIFO_empty,
    input  gemmFIFO_rdata, gemmFIFO_empty,
    input  load_complete, gemm_complete
  );

endinterface

// File: rtl/sp_drain_stage.sv
// Drains a first-word-fall-through FIFO into a
// registered valid/ready stream (rdata/empty/ren in, outValid/outReady/outData out).
module sp_drain_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rdata,
  input  logic         empty,
  output logic         ren,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  // Pop whenever the output slot is free or being consumed.
  assign ren = !rst && !empty &&
               (!outValid || outReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (ren) begin
      outValid <= 1'b1;
      outData  <= rdata;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/scratchpad_bank_driver.sv
// Client-side driver for the scratchpad bank.
// ld_*/gm_* command and data in, *_done pulses, st_*/op_* streams out, sp bank port.
module scratchpad_bank_driver
  import sp_types_pkg::*;
#(
  parameter int DATA_W = SP_DATA_W,
  parameter int ROWS   = SP_ROWS,
  parameter int MAT_W  = SP_MAT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_cmd_valid,
  output logic              ld_cmd_ready,
  input  logic [MAT_W-1:0]  ld_cmd_mat,
  input  logic              ld_data_valid,
  output logic              ld_data_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done,
  input  logic              gm_cmd_valid,
  output logic              gm_cmd_ready,
  input  logic [MAT_W-1:0]  gm_cmd_a,
  input  logic [MAT_W-1:0]  gm_cmd_b,
  input  logic [MAT_W-1:0]  gm_cmd_c,
  input  logic [MAT_W-1:0]  gm_cmd_d,
  output logic              gm_done,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [$bits(dramFIFO_t)-1:0] st_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [$bits(gemmFIFO_t)-1:0] op_data,
  scratchpad_bank_if.drv    sp
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(ROWS - 1);

  wState_t          wState;
  wState_t          wNext;
  logic [MAT_W-1:0] matQ;
  logic [ROW_W-1:0] rowCnt;
  logic             ldDoneQ;
  logic             wPush;
  wFIFO_t           wData;

  rState_t          rState;
  rState_t          rNext;
  rFIFO_t           opQ;
  logic             gmDoneQ;
  logic             rWen;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wState <= W_IDLE;
    end else begin
      wState <= wNext;
    end
  end

  always_comb begin
    wNext = wState;
    unique case (wState)
      W_IDLE:
        if (ld_cmd_valid && ld_cmd_ready)
          wNext = W_PUSH;
      W_PUSH:
        if (wPush && rowCnt == LAST_ROW)
          wNext = W_WAIT;
      W_WAIT:
        if (sp.load_complete)
          wNext = W_IDLE;
      default:
        wNext = W_IDLE;
    endcase
  end

  always_comb begin
    ld_cmd_ready  = (wState == W_IDLE) && !RST;
    ld_data_ready = (wState == W_PUSH) &&
                    !sp.wFIFO_full;
    wPush = ld_data_ready && ld_data_valid;
    wData = '0;
    if (wState == W_PUSH) begin
      wData.mat  = matQ;
      wData.row  = rowCnt;
      wData.data = ld_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      matQ    <= '0;
      rowCnt  <= '0;
      ldDoneQ <= 1'b0;
    end else begin
      if (ld_cmd_valid && ld_cmd_ready) begin
        matQ   <= ld_cmd_mat;
        rowCnt <= '0;
      end else if (wPush) begin
        rowCnt <= rowCnt + 1'b1;
      end
      ldDoneQ <= (wState == W_WAIT) &&
                 sp.load_complete;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rState <= R_IDLE;
    end else begin
      rState <= rNext;
    end
  end

  always_comb begin
    rNext = rState;
    unique case (rState)
      R_IDLE:
        if (gm_cmd_valid && gm_cmd_ready)
          rNext = R_PUSH;
      R_PUSH:
        if (rWen)
          rNext = R_WAIT;
      R_WAIT:
        if (sp.gemm_complete)
          rNext = R_IDLE;
      default:
        rNext = R_IDLE;
    endcase
  end

  always_comb begin
    gm_cmd_ready = (rState == R_IDLE) && !RST;
    rWen = (rState == R_PUSH) &&
           !sp.rFIFO_full;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opQ     <= '0;
      gmDoneQ <= 1'b0;
    end else begin
      if (gm_cmd_valid && gm_cmd_ready) begin
        opQ.a <= gm_cmd_a;
        opQ.b <= gm_cmd_b;
        opQ.c <= gm_cmd_c;
        opQ.d <= gm_cmd_d;
      end
      gmDoneQ <= (rState == R_WAIT) &&
                 sp.gemm_complete;
    end
  end

  assign ld_done        = ldDoneQ;
  assign gm_done        = gmDoneQ;
  assign sp.wFIFO_WEN   = wPush;
  assign sp.wFIFO_wdata = wData;
  assign sp.rFIFO_WEN   = rWen;
  assign sp.rFIFO_wdata = opQ;

  sp_drain_stage #(
    .W($bits(dramFIFO_t))
  ) uStDrain (
    .clk      (CLK),
    .rst      (RST),
    .rdata    (sp.dramFIFO_rdata),
    .empty    (sp.dramFIFO_empty),
    .ren      (sp.dramFIFO_REN),
    .outValid (st_valid),
    .outReady (st_ready),
    .outData  (st_data)
  );

  sp_drain_stage #(
    .W($bits(gemmFIFO_t))
  ) uOpDrain (
    .clk      (CLK),
    .rst      (RST),
    .rdata    (sp.gemmFIFO_rdata),
    .empty    (sp.gemmFIFO_empty),
    .ren      (sp.gemmFIFO_REN),
    .outValid (op_valid),
    .outReady (op_ready),
    .outData  (op_data)
  );

endmodule

// File: tb/tb_scratchpad_bank_driver.sv
// Bench for scratchpad_bank_driver: bank model,
// scoreboard queues and a negedge monitor.
module tb_scratchpad_bank_driver;
  import sp_types_pkg::*;

  logic CLK;
  logic RST;
  logic ld_cmd_valid, ld_cmd_ready;
  logic [SP_MAT_W-1:0] ld_cmd_mat;
  logic ld_data_valid, ld_data_ready;
  logic [SP_DATA_W-1:0] ld_data;
  logic ld_done;
  logic gm_cmd_valid, gm_cmd_ready;
  logic [SP_MAT_W-1:0] gm_cmd_a, gm_cmd_b;
  logic [SP_MAT_W-1:0] gm_cmd_c, gm_cmd_d;
  logic gm_done;
  logic st_valid, st_ready;
  logic [$bits(dramFIFO_t)-1:0] st_data;
  logic op_valid, op_ready;
  logic [$bits(gemmFIFO_t)-1:0] op_data;

  scratchpad_bank_if spIf();

  scratchpad_bank_driver dut (
    .CLK           (CLK),
    .RST           (RST),
    .ld_cmd_valid  (ld_cmd_valid),
    .ld_cmd_ready  (ld_cmd_ready),
    .ld_cmd_mat    (ld_cmd_mat),
    .ld_data_valid (ld_data_valid),
    .ld_data_ready (ld_data_ready),
    .ld_data       (ld_data),
    .ld_done       (ld_done),
    .gm_cmd_valid  (gm_cmd_valid),
    .gm_cmd_ready  (gm_cmd_ready),
    .gm_cmd_a      (gm_cmd_a),
    .gm_cmd_b      (gm_cmd_b),
    .gm_cmd_c      (gm_cmd_c),
    .gm_cmd_d      (gm_cmd_d),
    .gm_done       (gm_done),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_data       (st_data),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_data       (op_data),
    .sp            (spIf)
  );

  // Scoreboard: only the stimulus side appends.
  wFIFO_t    expW[$];
  rFIFO_t    expR[$];
  dramFIFO_t dramReq[$];
  gemmFIFO_t gemmReq[$];

  dramFIFO_t dramQ[$];
  gemmFIFO_t gemmQ[$];
  int dIn, gIn;
  bit dRen, gRen;

  int  vectors, miscompares;
  int  tmoReq, tmoSeen;
  bit  done;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Bank model: FWFT queues popped on sampled REN.
  always @(posedge CLK) begin
    #1;
    if (dRen && dramQ.size() > 0)
      void'(dramQ.pop_front());
    if (gRen && gemmQ.size() > 0)
      void'(gemmQ.pop_front());
    while (dIn < dramReq.size()) begin
      dramQ.push_back(dramReq[dIn]);
      dIn++;
    end
    while (gIn < gemmReq.size()) begin
      gemmQ.push_back(gemmReq[gIn]);
      gIn++;
    end
    spIf.dramFIFO_empty = (dramQ.size() == 0);
    spIf.dramFIFO_rdata =
      (dramQ.size() > 0) ? dramQ[0] : '0;
    spIf.gemmFIFO_empty = (gemmQ.size() == 0);
    spIf.gemmFIFO_rdata =
      (gemmQ.size() > 0) ? gemmQ[0] : '0;
  end

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  int  wIdx, rIdx, stIdx, opIdx;
  bit  lWait, gWait, expLd, expGm;
  bit  rstPrev, stHold, opHold;
  logic [$bits(dramFIFO_t)-1:0] stPrev;
  logic [$bits(gemmFIFO_t)-1:0] opPrev;
  logic [14:0] rv;
  bit  nxtLd, nxtGm;

  always @(negedge CLK) begin
    dRen = spIf.dramFIFO_REN;
    gRen = spIf.gemmFIFO_REN;
    if (tmoReq != tmoSeen) begin
      tmoSeen = tmoReq;
      chk("handshake_timeout", 128'(1), 128'(0));
    end
    if (RST) begin
      rv = {ld_cmd_ready, ld_data_ready, ld_done,
            gm_cmd_ready, gm_done, st_valid,
            op_valid, |st_data, |op_data,
            spIf.wFIFO_WEN, |spIf.wFIFO_wdata,
            spIf.rFIFO_WEN, |spIf.rFIFO_wdata,
            spIf.dramFIFO_REN, spIf.gemmFIFO_REN};
      chk("reset_outputs", 128'(rv), 128'(0));
      lWait = 0; gWait = 0;
      expLd = 0; expGm = 0;
      stHold = 0; opHold = 0;
      rstPrev = 1;
    end else begin
      if (rstPrev)
        chk("cmd_ready_after_reset",
            128'({ld_cmd_ready, gm_cmd_ready}),
            128'(2'b11));
      rstPrev = 0;
      chk("ld_done", 128'(ld_done), 128'(expLd));
      chk("gm_done", 128'(gm_done), 128'(expGm));
      nxtLd = lWait && spIf.load_complete;
      nxtGm = gWait && spIf.gemm_complete;
      if (nxtLd) lWait = 0;
      if (nxtGm) gWait = 0;
      if (spIf.wFIFO_full)
        chk("wfifo_stall",
            128'({ld_data_ready, spIf.wFIFO_WEN}),
            128'(0));
      if (spIf.wFIFO_WEN) begin
        if (wIdx < expW.size()) begin
          chk("wfifo_push",
              128'(spIf.wFIFO_wdata),
              128'(expW[wIdx]));
          if (int'(expW[wIdx].row) == SP_ROWS - 1)
            lWait = 1;
          wIdx++;
        end else begin
          chk("wfifo_unexpected", 128'(1), 128'(0));
        end
      end
      if (spIf.rFIFO_full)
        chk("rfifo_stall",
            128'(spIf.rFIFO_WEN), 128'(0));
      if (spIf.rFIFO_WEN) begin
        if (rIdx < expR.size()) begin
          chk("rfifo_push",
              128'(spIf.rFIFO_wdata),
              128'(expR[rIdx]));
          gWait = 1;
          rIdx++;
        end else begin
          chk("rfifo_unexpected", 128'(1), 128'(0));
        end
      end
      if (stHold)
        chk("st_hold",
            128'({st_valid, st_data}),
            128'({1'b1, stPrev}));
      if (st_valid && st_ready) begin
        if (stIdx < dramReq.size())
          chk("st_data", 128'(st_data),
              128'(dramReq[stIdx]));
        else
          chk("st_unexpected", 128'(1), 128'(0));
        stIdx++;
      end
      stHold = st_valid && !st_ready;
      stPrev = st_data;
      if (opHold)
        chk("op_hold", 128'(op_data),
            128'(opPrev));
      if (opHold)
        chk("op_hold_valid", 128'(op_valid),
            128'(1));
      if (op_valid && op_ready) begin
        if (opIdx < gemmReq.size())
          chk("op_data", 128'(op_data),
              128'(gemmReq[opIdx]));
        else
          chk("op_unexpected", 128'(1), 128'(0));
        opIdx++;
      end
      opHold = op_valid && !op_ready;
      opPrev = op_data;
      expLd = nxtLd;
      expGm = nxtGm;
    end
    if (done) begin
      chk("wfifo_count", 128'(wIdx),
          128'(expW.size()));
      chk("rfifo_count", 128'(rIdx),
          128'(expR.size()));
      chk("st_count", 128'(stIdx),
          128'(dramReq.size()));
      chk("op_count", 128'(opIdx),
          128'(gemmReq.size()));
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic doLoad(input logic [SP_MAT_W-1:0] mat,
                        input int base,
                        input int fullAt,
                        input int fullLen,
                        input int abortAt,
                        input int cplDly,
                        input bit gaps);
    bit acc;
    int n;
    wFIFO_t e;
    ld_cmd_mat = mat;
    ld_cmd_valid = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 60) begin
      @(negedge CLK);
      acc = ld_cmd_ready;
      @(posedge CLK); #1;
      n++;
    end
    ld_cmd_valid = 1'b0;
    if (!acc) tmoReq++;
    for (int i = 0; i < SP_ROWS; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_data_valid = 1'b0;
        tick($urandom_range(1, 2));
      end
      e.mat  = mat;
      e.row  = SP_ROW_W'(i);
      e.data = (base >= 0) ? 64'(base + i)
                           : {$urandom, $urandom};
      ld_data = e.data;
      ld_data_valid = 1'b1;
      expW.push_back(e);
      if (i - 1 == fullAt && fullLen > 0) begin
        spIf.wFIFO_full = 1'b1;
        tick(fullLen);
        spIf.wFIFO_full = 1'b0;
      end
      acc = 0; n = 0;
      while (!acc && n < 60) begin
        @(negedge CLK);
        acc = ld_data_ready;
        @(posedge CLK); #1;
        n++;
      end
      if (!acc) tmoReq++;
      if (i == abortAt) begin
        ld_data_valid = 1'b0;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        return;
      end
    end
    ld_data_valid = 1'b0;
    tick(cplDly);
    spIf.load_complete = 1'b1;
    tick(1);
    spIf.load_complete = 1'b0;
    tick(2);
  endtask

  task automatic doGemm(input logic [SP_MAT_W-1:0] a,
                        input logic [SP_MAT_W-1:0] b,
                        input logic [SP_MAT_W-1:0] c,
                        input logic [SP_MAT_W-1:0] d,
                        input int fullLen);
    bit acc;
    int n;
    rFIFO_t e;
    e.a = a; e.b = b; e.c = c; e.d = d;
    gm_cmd_a = a; gm_cmd_b = b;
    gm_cmd_c = c; gm_cmd_d = d;
    gm_cmd_valid = 1'b1;
    if (fullLen > 0) spIf.rFIFO_full = 1'b1;
    expR.push_back(e);
    acc = 0; n = 0;
    while (!acc && n < 60) begin
      @(negedge CLK);
      acc = gm_cmd_ready;
      @(posedge CLK); #1;
      n++;
    end
    gm_cmd_valid = 1'b0;
    if (!acc) tmoReq++;
    if (fullLen > 0) begin
      tick(fullLen);
      spIf.rFIFO_full = 1'b0;
    end
    tick(2);
    spIf.gemm_complete = 1'b1;
    tick(1);
    spIf.gemm_complete = 1'b0;
    tick(2);
  endtask

  function automatic dramFIFO_t rndDram();
    dramFIFO_t e;
    e.mat  = SP_MAT_W'($urandom);
    e.row  = SP_ROW_W'($urandom);
    e.data = {$urandom, $urandom};
    return e;
  endfunction

  function automatic gemmFIFO_t rndGemm();
    gemmFIFO_t e;
    e.aRow = {$urandom, $urandom};
    e.bRow = {$urandom, $urandom};
    return e;
  endfunction

  bit pat[5];

  initial begin
    RST = 1'b1;
    ld_cmd_valid = 0; ld_cmd_mat = '0;
    ld_data_valid = 0; ld_data = '0;
    gm_cmd_valid = 0;
    gm_cmd_a = '0; gm_cmd_b = '0;
    gm_cmd_c = '0; gm_cmd_d = '0;
    st_ready = 1; op_ready = 1;
    spIf.wFIFO_full = 0; spIf.rFIFO_full = 0;
    spIf.load_complete = 0;
    spIf.gemm_complete = 0;
    done = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    // Entry waiting in the bank while reset holds.
    dramReq.push_back(rndDram());
    gemmReq.push_back(rndGemm());
    tick(3);
    RST = 1'b0;
    tick(3);

    doLoad(4'd3, 'hA0, -1, 0, -1, 2, 0);
    doLoad(4'd5, -1, 1, 5, -1, 1, 0);
    fork
      doGemm(4'd1, 4'd2, 4'd3, 4'd4, 3);
      doLoad(4'd7, -1, -1, 0, -1, 2, 0);
    join

    op_ready = 1'b0;
    repeat (3) gemmReq.push_back(rndGemm());
    tick(3);
    for (int k = 0; k < 5; k++) begin
      op_ready = pat[k];
      tick(1);
    end
    op_ready = 1'b1;
    tick(5);

    doLoad(4'd9, -1, -1, 0, 2, 0, 0);
    spIf.load_complete = 1'b1;
    tick(1);
    spIf.load_complete = 1'b0;
    tick(3);
    doLoad(4'd10, -1, -1, 0, -1, 1, 0);

    fork
      begin
        for (int j = 0; j < 6; j++)
          doLoad(SP_MAT_W'($urandom), -1,
                 $urandom_range(0, 3) - 1,
                 $urandom_range(1, 4), -1,
                 $urandom_range(0, 3), 1);
      end
      begin
        for (int j = 0; j < 6; j++)
          doGemm(SP_MAT_W'($urandom),
                 SP_MAT_W'($urandom),
                 SP_MAT_W'($urandom),
                 SP_MAT_W'($urandom),
                 $urandom_range(0, 3));
      end
      begin
        repeat (150) begin
          if ($urandom_range(0, 2) == 0)
            dramReq.push_back(rndDram());
          if ($urandom_range(0, 2) == 0)
            gemmReq.push_back(rndGemm());
          st_ready = 1'($urandom);
          op_ready = 1'($urandom);
          tick(1);
        end
      end
    join
    st_ready = 1'b1;
    op_ready = 1'b1;
    tick(20);
    done = 1'b1;
    tick(3);
  end

endmodule
